// File: rtl/ex_muldiv_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit for the EX stage, results land in HI/LO.
// Latency: accept cycle + 32 BUSY iterations, HI/LO written at the end of the last one, then one DONE cycle.
// Backpressure: stall_o holds the pipeline from accept through the last BUSY cycle and drops in DONE.
module ex_muldiv_unit (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] rs_data_i,
  input  logic [31:0] rt_data_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        busy_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [4:0]  count;
  logic [63:0] acc;        // mult: {partial product, remaining multiplier}; div: {remainder, dividend/quotient}
  logic [31:0] b_mag;      // multiplicand or divisor magnitude
  logic        is_div;
  logic        neg_q;      // negate product (mult) or quotient (div)
  logic        neg_r;      // negate remainder (div only)

  logic        accept;
  logic        last_iter;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag_in;
  logic [31:0] b_mag_in;
  logic [32:0] mul_sum;
  logic [63:0] mul_nxt;
  logic [32:0] div_shift;
  logic [32:0] div_diff;
  logic [63:0] div_nxt;
  logic [63:0] iter_nxt;
  logic [63:0] prod_fix;
  logic [31:0] fix_hi;
  logic [31:0] fix_lo;

  assign accept    = (state == IDLE) && start_i && !flush_i;
  assign last_iter = (state == BUSY) && !flush_i && (count == 5'd31);

  // Operand magnitudes; magnitude of 0x80000000 is 0x80000000, which still fits 32 unsigned bits
  always_comb begin
    a_neg    = !op_i[0] && rs_data_i[31];
    b_neg    = !op_i[0] && rt_data_i[31];
    a_mag_in = a_neg ? (32'd0 - rs_data_i) : rs_data_i;
    b_mag_in = b_neg ? (32'd0 - rt_data_i) : rt_data_i;
  end

  // One shift-add or one restoring-divide step, plus the final sign fixup
  always_comb begin
    mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, b_mag} : 33'd0);
    mul_nxt   = {mul_sum, acc[31:1]};
    div_shift = {acc[63:32], acc[31]};
    div_diff  = div_shift - {1'b0, b_mag};
    if (div_diff[32]) begin
      div_nxt = {div_shift[31:0], acc[30:0], 1'b0};
    end else begin
      div_nxt = {div_diff[31:0], acc[30:0], 1'b1};
    end
    iter_nxt = is_div ? div_nxt : mul_nxt;
    prod_fix = neg_q ? (64'd0 - iter_nxt) : iter_nxt;
    if (is_div) begin
      fix_lo = neg_q ? (32'd0 - iter_nxt[31:0])  : iter_nxt[31:0];
      fix_hi = neg_r ? (32'd0 - iter_nxt[63:32]) : iter_nxt[63:32];
    end else begin
      fix_lo = prod_fix[31:0];
      fix_hi = prod_fix[63:32];
    end
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and pipeline-control outputs
  always_comb begin
    state_nxt = state;
    stall_o   = 1'b0;
    busy_o    = 1'b0;
    case (state)
      IDLE: begin
        if (start_i && !flush_i) begin
          state_nxt = BUSY;
          stall_o   = 1'b1;
        end
      end
      BUSY: begin
        stall_o = 1'b1;
        busy_o  = 1'b1;
        if (flush_i) begin
          state_nxt = IDLE;
        end else if (count == 5'd31) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: latch operands at accept, iterate in BUSY, commit HI/LO on the last iteration
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count  <= 5'd0;
      acc    <= 64'd0;
      b_mag  <= 32'd0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi_o   <= 32'd0;
      lo_o   <= 32'd0;
    end else if (accept) begin
      count  <= 5'd0;
      acc    <= {32'd0, a_mag_in};
      b_mag  <= b_mag_in;
      is_div <= op_i[1];
      // Divide by zero must leave LO all ones, so the quotient is never negated then
      neg_q  <= (a_neg ^ b_neg) && !(op_i[1] && (rt_data_i == 32'd0));
      neg_r  <= op_i[1] && a_neg;
    end else if ((state == BUSY) && !flush_i) begin
      acc   <= iter_nxt;
      count <= count + 5'd1;
      if (last_iter) begin
        hi_o <= fix_hi;
        lo_o <= fix_lo;
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: arithmetic results, stall timing, flush/reset aborts, back-to-back ops.
// Inputs change 1 time unit after each rising edge; outputs are checked 1 unit later.
// Every op waits on stall_o with a bounded cycle budget.
module tb_ex_muldiv_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] rs_data_i;
  logic [31:0] rt_data_i;
  logic        flush_i;
  logic        stall_o;
  logic        busy_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int checks = 0;
  int fails  = 0;
  int cnt;
  int busy_cnt;

  ex_muldiv_unit dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .op_i      (op_i),
    .rs_data_i (rs_data_i),
    .rt_data_i (rt_data_i),
    .flush_i   (flush_i),
    .stall_o   (stall_o),
    .busy_o    (busy_o),
    .hi_o      (hi_o),
    .lo_o      (lo_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Counts stalled cycles from the current (accept) cycle until stall_o drops, scrambling operands after accept
  task automatic run_to_done();
    cnt      = 0;
    busy_cnt = 0;
    while (stall_o && cnt < 40) begin
      cnt++;
      if (busy_o) busy_cnt++;
      step();
      if (cnt == 1) begin
        rs_data_i = 32'h1234_5678;
        rt_data_i = 32'h0000_0003;
      end
    end
  endtask

  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    op_i      = op;
    rs_data_i = a;
    rt_data_i = b;
    start_i   = 1'b1;
    #1;
    run_to_done();
    check({tag, " stall_cycles"}, cnt, 33);
    check({tag, " busy_cycles"}, busy_cnt, 32);
    start_i = 1'b0;
    #1;
    check({tag, " hi"}, hi_o, exp_hi);
    check({tag, " lo"}, lo_o, exp_lo);
    check({tag, " done_busy"}, {31'd0, busy_o}, 32'd0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_i     = 1'b1;
    start_i   = 1'b1;
    flush_i   = 1'b0;
    op_i      = 2'b01;
    rs_data_i = 32'hFFFF_FFFF;
    rt_data_i = 32'hFFFF_FFFF;
    step();
    step();
    check("reset hi", hi_o, 32'd0);
    check("reset lo", lo_o, 32'd0);
    check("reset busy", {31'd0, busy_o}, 32'd0);

    // Release reset with start held: MULTU 0xFFFFFFFF^2 starts on the first edge
    rst_i = 1'b0;
    #1;
    check("post-reset accept stall", {31'd0, stall_o}, 32'd1);
    run_to_done();
    check("multu stall_cycles", cnt, 33);
    check("multu busy_cycles", busy_cnt, 32);
    start_i = 1'b0;
    #1;
    check("multu done stall", {31'd0, stall_o}, 32'd0);
    check("multu hi", hi_o, 32'hFFFF_FFFE);
    check("multu lo", lo_o, 32'h0000_0001);
    step();

    do_op("mult -3*7",     2'b00, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB);
    do_op("mult min*min",  2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    do_op("div -7/2",      2'b10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
    do_op("divu 100/7",    2'b11, 32'd100,       32'd7,        32'h0000_0002, 32'h0000_000E);
    do_op("div min/-1",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    do_op("div -5/0",      2'b10, 32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF);
    do_op("divu 5/0",      2'b11, 32'd5,         32'd0,        32'h0000_0005, 32'hFFFF_FFFF);

    // Flush at T10: back to IDLE, HI/LO keep the DIVU 5/0 result
    op_i      = 2'b01;
    rs_data_i = 32'd3;
    rt_data_i = 32'd4;
    start_i   = 1'b1;
    #1;
    for (int i = 0; i < 10; i++) step();
    start_i = 1'b0;
    flush_i = 1'b1;
    #1;
    check("flush T10 stall", {31'd0, stall_o}, 32'd1);
    step();
    flush_i = 1'b0;
    #1;
    check("flush stall", {31'd0, stall_o}, 32'd0);
    check("flush busy", {31'd0, busy_o}, 32'd0);
    check("flush hi", hi_o, 32'h0000_0005);
    check("flush lo", lo_o, 32'hFFFF_FFFF);

    // Flush in IDLE overrides start
    flush_i = 1'b1;
    start_i = 1'b1;
    #1;
    check("idle flush stall", {31'd0, stall_o}, 32'd0);
    step();
    check("idle flush busy", {31'd0, busy_o}, 32'd0);
    flush_i = 1'b0;
    start_i = 1'b0;
    step();

    // Reset at T20 clears HI/LO and aborts
    start_i = 1'b1;
    #1;
    for (int i = 0; i < 20; i++) step();
    check("pre-reset busy", {31'd0, busy_o}, 32'd1);
    start_i = 1'b0;
    rst_i   = 1'b1;
    step();
    rst_i = 1'b0;
    #1;
    check("midrst hi", hi_o, 32'd0);
    check("midrst lo", lo_o, 32'd0);
    check("midrst busy", {31'd0, busy_o}, 32'd0);
    check("midrst stall", {31'd0, stall_o}, 32'd0);
    step();

    // Back-to-back: MULTU 3*4 then DIVU 9/2, start held through the first DONE
    op_i      = 2'b01;
    rs_data_i = 32'd3;
    rt_data_i = 32'd4;
    start_i   = 1'b1;
    #1;
    run_to_done();
    check("b2b op1 stall_cycles", cnt, 33);
    check("b2b op1 hi", hi_o, 32'd0);
    check("b2b op1 lo", lo_o, 32'd12);
    op_i      = 2'b11;
    rs_data_i = 32'd9;
    rt_data_i = 32'd2;
    step();
    check("b2b T34 stall", {31'd0, stall_o}, 32'd1);
    check("b2b T34 busy", {31'd0, busy_o}, 32'd0);
    run_to_done();
    check("b2b op2 stall_cycles", cnt, 33);
    start_i = 1'b0;
    #1;
    check("b2b op2 hi", hi_o, 32'd1);
    check("b2b op2 lo", lo_o, 32'd4);
    step();
    check("b2b idle busy", {31'd0, busy_o}, 32'd0);
    check("b2b idle stall", {31'd0, stall_o}, 32'd0);
    step();
    check("b2b final hi", hi_o, 32'd1);
    check("b2b final lo", lo_o, 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Iterative multiply/divide unit in the EX stage. It consumes the operand and opcode fields the ID/EX pipeline register presents, and computes MULT/MULTU/DIV/DIVU over 32 cycles into architectural HI/LO registers. While it works, it stalls the pipeline so the instruction holds in EX. It drives a one-cycle release so ID/EX can advance without re-triggering the operation.

## Interface
- No parameters; datapath fixed at 32 bits.
- clk_i  input  1  pipeline clock; all state updates on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- start_i  input  1  EX holds a mult/div instruction (decoded from ID/EX opcode/funct).
- op_i  input  2  funct[1:0]: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- rs_data_i  input  32  operand A (multiplicand / dividend), from ID/EX rs_data.
- rt_data_i  input  32  operand B (multiplier / divisor), from ID/EX rt_data.
- flush_i  input  1  kill the in-flight operation (taken branch resolved downstream).
- stall_o  output  1  hold PC, IF/ID and ID/EX this cycle.
- busy_o  output  1  FSM in BUSY.
- hi_o  output  32  HI register (product[63:32] / remainder).
- lo_o  output  32  LO register (product[31:0] / quotient).

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - When start_i=1 and flush_i=0: latch operand magnitudes and the result-sign flags (signed ops only), clear the accumulator, set count=0, go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - Each cycle performs one iteration and increments count (5 bits).
  - Multiply: shift-add, one multiplier bit per cycle.
  - Divide: restoring, one quotient bit per cycle.
  - On the edge where count==31: perform the final iteration, apply sign fixup, write HI/LO, go to DONE.
- DONE: lasts exactly one cycle. start_i is ignored here. Go to IDLE.
- flush_i=1 in BUSY or DONE: go to IDLE next edge; HI/LO unchanged if not yet written.
- flush_i=1 in IDLE: start_i is ignored.
- Sign rules for signed ops:
  - Product is negated if sign(A)^sign(B).
  - Quotient is negated if sign(A)^sign(B).
  - Remainder takes the sign of A.
  - Unsigned ops use raw operands.
- Divide by zero (B==0), any signedness: LO=0xFFFFFFFF, HI=A. Still takes 32 BUSY cycles.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000. No trap.
- Product is 64-bit exact. MULT operand 0x80000000 is handled via a 33-bit magnitude or an equivalent method.
- HI/LO are written only at BUSY→DONE and by reset.

## Timing
- stall_o = (IDLE & start_i & ~flush_i) | BUSY. It is low in DONE.
- Accept cycle (T0) has stall_o=1. Cycles T1..T32 are BUSY with stall_o=1 and busy_o=1.
- HI/LO are updated at the end of T32. DONE is T33 with stall_o=0, so ID/EX advances.
- Total occupancy is 34 cycles per operation. The 33 stalled cycles are T0–T32.
- A back-to-back mult/div arriving in EX at T34 (IDLE) is accepted immediately.
- hi_o/lo_o are register outputs. A dependent MFHI/MFLO reading in T33 or later sees the new value.
- Reset (rst_i=1 at an edge), including mid-BUSY:
  - Aborts the operation; state becomes IDLE, count=0.
  - hi_o=0, lo_o=0, stall_o=0 (when start_i=0), busy_o=0 from the next cycle.
- rst_i has priority over flush_i, which has priority over start_i.
- Operands are sampled only at the accept edge. Later changes on rs/rt_data_i are ignored.

## Test plan
- Reset: assert rst_i 2 cycles with start_i=1 → hi_o=lo_o=0 and busy_o=0; after release, the op starts on the first edge.
- MULTU: A=B=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. stall_o high exactly 33 cycles, then low 1 cycle (DONE).
- MULT: A=-3, B=7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- MULT: A=B=0x80000000 → HI=0x40000000, LO=0.
- Divide:
  - DIV -7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU 100/7 → LO=0x0000000E, HI=0x00000002.
  - DIVU 5/0 → LO=0xFFFFFFFF, HI=0x00000005.
- Abort:
  - flush_i at T10 → IDLE next cycle, HI/LO hold prior values, stall_o drops.
  - rst_i at T20 → HI/LO=0.
- Back-to-back:
  - MULTU 3×4 then DIVU 9/2 with start_i held high through DONE → exactly two operations.
  - Final HI/LO = 1/4; no re-trigger in DONE.
